alu_issue_ctrl: RTL

Sequential initiator that drives the datapath ALU (module alu, control codes 0-15), the initiator side of the ALU operand/result interface.
- Accepts operation commands over a valid/ready handshake.
- Registers operands and opcode onto the ALU inputs and waits one cycle for the ALU to settle.
- Captures result and flags, and returns them with a tag over a second valid/ready handshake.
- Used by the multi-cycle control path and by the hardware self-test sequencer.

---
 rtl/alu_issue_ctrl_pkg.sv | 27 ++
 rtl/alu.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU control codes and issue-controller FSM state encoding.
package alu_issue_ctrl_pkg;

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpAnd  = 4'd2;
    localparam logic [3:0] OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4;
    localparam logic [3:0] OpLsh  = 4'd5;
    localparam logic [3:0] OpRsh  = 4'd6;
    localparam logic [3:0] OpNand = 4'd7;
    localparam logic [3:0] OpNor  = 4'd8;
    localparam logic [3:0] OpXnor = 4'd9;
    localparam logic [3:0] OpNot  = 4'd10;
    localparam logic [3:0] OpComp = 4'd11;
    localparam logic [3:0] OpAddo = 4'd12;
    localparam logic [3:0] OpSubo = 4'd13;
    localparam logic [3:0] OpSig  = 4'd14;
    localparam logic [3:0] OpSome = 4'd15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/alu.sv
// Combinational datapath ALU: 16 control codes, carry/overflow, equal and zero flags.
module alu
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WITH = 32
) (
    input  logic [DATA_WITH-1:0] rega,
    input  logic [DATA_WITH-1:0] regb,
    input  logic [3:0]           control,
    output logic [DATA_WITH-1:0] out_alu,
    output logic                 cout,
    output logic                 equal,
    output logic                 zero
);

    localparam int unsigned ShW = $clog2(DATA_WITH);

    logic [DATA_WITH:0] sum;
    logic [DATA_WITH:0] diff;

    assign sum  = {1'b0, rega} + {1'b0, regb};
    assign diff = {1'b0, rega} - {1'b0, regb};

    always_comb begin
        out_alu = '0;
        cout    = 1'b0;
        unique case (control)
            OpAdd:  begin out_alu = sum[DATA_WITH-1:0];  cout = sum[DATA_WITH];  end
            OpSub:  begin out_alu = diff[DATA_WITH-1:0]; cout = diff[DATA_WITH]; end
            OpAnd:  out_alu = rega & regb;
            OpOr:   out_alu = rega | regb;
            OpXor:  out_alu = rega ^ regb;
            OpLsh:  out_alu = rega << regb[ShW-1:0];
            OpRsh:  out_alu = rega >> regb[ShW-1:0];
            OpNand: out_alu = ~(rega & regb);
            OpNor:  out_alu = ~(rega | regb);
            OpXnor: out_alu = ~(rega ^ regb);
            OpNot:  out_alu = ~rega;
            OpComp: out_alu = {{(DATA_WITH-1){1'b0}}, rega < regb};
            // ADDO/SUBO report signed overflow on cout instead of carry
            OpAddo: begin
                out_alu = sum[DATA_WITH-1:0];
                cout    = (rega[DATA_WITH-1] == regb[DATA_WITH-1]) &&
                          (sum[DATA_WITH-1] != rega[DATA_WITH-1]);
            end
            OpSubo: begin
                out_alu = diff[DATA_WITH-1:0];
                cout    = (rega[DATA_WITH-1] != regb[DATA_WITH-1]) &&
                          (diff[DATA_WITH-1] != rega[DATA_WITH-1]);
            end
            OpSig:  out_alu = {{(DATA_WITH-1){1'b0}}, rega[DATA_WITH-1]};
            OpSome: out_alu = {{(DATA_WITH-1){1'b0}}, |rega};
            default: out_alu = '0;
        endcase
    end

    assign equal = (rega == regb);
    assign zero  = (out_alu == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues registered operand/opcode to the ALU, captures result one cycle later, returns it tagged.
// Optional reference checker compiled in with macro ALU_SELFCHECK_EN.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WITH = 32,
    parameter int unsigned TAG_W     = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [DATA_WITH-1:0] cmd_a,
    input  logic [DATA_WITH-1:0] cmd_b,
    input  logic [3:0]           cmd_op,
    input  logic [TAG_W-1:0]     cmd_tag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_WITH-1:0] rsp_data,
    output logic                 rsp_cout,
    output logic                 rsp_equal,
    output logic                 rsp_zero,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 busy,
    output logic [CNT_W-1:0]     op_count,
    output logic                 chk_err
);

    state_e state_q, state_d;

    logic [DATA_WITH-1:0] alu_a_q, alu_b_q;
    logic [3:0]           alu_op_q;
    logic [TAG_W-1:0]     tag_q;
    logic [DATA_WITH-1:0] alu_out;
    logic                 alu_cout, alu_equal, alu_zero;

    logic [DATA_WITH-1:0] rsp_data_q;
    logic                 rsp_cout_q, rsp_equal_q, rsp_zero_q;
    logic [TAG_W-1:0]     rsp_tag_q;
    logic [CNT_W-1:0]     op_count_q;

    logic cmd_fire, rsp_fire;

    assign cmd_fire = cmd_valid & cmd_ready;
    assign rsp_fire = rsp_valid & rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cmd_valid) state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  if (rsp_ready) state_d = cmd_valid ? StExec : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // rsp_valid follows state directly so it drops as soon as reset asserts
    always_comb begin
        cmd_ready = (state_q == StIdle) | ((state_q == StResp) & rsp_ready);
        rsp_valid = (state_q == StResp);
        busy      = (state_q == StExec) | (state_q == StResp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            tag_q       <= '0;
            rsp_data_q  <= '0;
            rsp_cout_q  <= 1'b0;
            rsp_equal_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_tag_q   <= '0;
            op_count_q  <= '0;
        end else begin
            if (cmd_fire) begin
                alu_a_q  <= cmd_a;
                alu_b_q  <= cmd_b;
                alu_op_q <= cmd_op;
                tag_q    <= cmd_tag;
            end
            if (state_q == StExec) begin
                rsp_data_q  <= alu_out;
                rsp_cout_q  <= alu_cout;
                rsp_equal_q <= alu_equal;
                rsp_zero_q  <= alu_zero;
                rsp_tag_q   <= tag_q;
            end
            if (rsp_fire) begin
                op_count_q <= op_count_q + CNT_W'(1);
            end
        end
    end

    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_equal = rsp_equal_q;
    assign rsp_zero  = rsp_zero_q;
    assign rsp_tag   = rsp_tag_q;
    assign op_count  = op_count_q;

    alu #(
        .DATA_WITH (DATA_WITH)
    ) u_alu (
        .rega    (alu_a_q),
        .regb    (alu_b_q),
        .control (alu_op_q),
        .out_alu (alu_out),
        .cout    (alu_cout),
        .equal   (alu_equal),
        .zero    (alu_zero)
    );

`ifdef ALU_SELFCHECK_EN
    logic [DATA_WITH-1:0] ref_data;
    logic                 ref_chk;
    logic                 mismatch;
    logic                 chk_err_q;

    always_comb begin
        ref_data = '0;
        ref_chk  = 1'b1;
        case (alu_op_q)
            OpAdd:   ref_data = alu_a_q + alu_b_q;
            OpSub:   ref_data = alu_a_q - alu_b_q;
            OpAnd:   ref_data = alu_a_q & alu_b_q;
            OpOr:    ref_data = alu_a_q | alu_b_q;
            OpXor:   ref_data = alu_a_q ^ alu_b_q;
            default: ref_chk  = 1'b0;
        endcase
        mismatch = (ref_chk && (ref_data != alu_out)) ||
                   ((alu_op_q == OpComp) && (alu_equal != (alu_a_q == alu_b_q)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_err_q <= 1'b0;
        end else if ((state_q == StExec) && mismatch) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;
`else
    assign chk_err = 1'b0;
`endif

endmodule
